// File: rtl/conv_2x2_tile_sched_if.sv
// Bundle between the tile scheduler, the line-buffer read port, the conv core result
// and the downstream result writer.
//   master : scheduler side (drives rd_req/rd_row/rd_col and the out_* tile)
//   slave  : environment side (drives rd_ack, core_out and out_ready)
interface conv_2x2_tile_sched_if #(
  parameter int unsigned ROW_W  = 8,
  parameter int unsigned TILE_W = 8
);
  logic              rd_req;
  logic [ROW_W-1:0]  rd_row;
  logic [TILE_W+1:0] rd_col;
  logic              rd_ack;
  logic [63:0]       core_out;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_data;
  logic [ROW_W-1:0]  out_row;
  logic [TILE_W+1:0] out_col;

  modport master (
    output rd_req, rd_row, rd_col, out_valid, out_data, out_row, out_col,
    input  rd_ack, core_out, out_ready
  );

  modport slave (
    input  rd_req, rd_row, rd_col, out_valid, out_data, out_row, out_col,
    output rd_ack, core_out, out_ready
  );
endinterface

// File: rtl/conv_2x2_tile_sched.sv
// Tile sequencer for the 3-channel 2x2 convolution core. Walks the output feature map in
// raster order of 1x4 output tiles: requests each input window, waits CORE_LAT cycles for
// the core, captures the 4x16b result and hands it downstream with a valid/ready handshake.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             pulse in IDLE: latch cfg_* and begin a frame
//   abort             drop the current frame, back to IDLE next cycle, no done pulse
//   cfg_out_rows      output rows per frame
//   cfg_tiles         output tiles (of 4 columns) per row
//   bus (master)      rd_req/rd_row/rd_col/rd_ack window request, core_out result,
//                     out_valid/out_ready/out_data/out_row/out_col result tile
//   busy              frame in progress (low in the done cycle)
//   done              one-cycle pulse after the last tile
//   perf_stall_cnt    only with CONV_SCHED_PERF_EN defined: saturating count of cycles
//                     stalled on rd_ack or out_ready
//
// Build option: define CONV_SCHED_PERF_EN to add the stall counter.
module conv_2x2_tile_sched #(
  parameter int unsigned CORE_LAT = 1,
  parameter int unsigned ROW_W    = 8,
  parameter int unsigned TILE_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [ROW_W-1:0]             cfg_out_rows,
  input  logic [TILE_W-1:0]            cfg_tiles,
  conv_2x2_tile_sched_if.master        bus,
  output logic                         busy,
  output logic                         done
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]                  perf_stall_cnt
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StEmit,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    rows_q, rows_d;
  logic [TILE_W-1:0]   tiles_q, tiles_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [TILE_W-1:0]   tile_q, tile_d;
  logic [3:0]          wait_q, wait_d;
  logic [63:0]         out_data_q;
  logic [ROW_W-1:0]    out_row_q;
  logic [TILE_W+1:0]   out_col_q;
  logic                done_q, done_d;
  logic                sample;
  logic                abort_hit;

  assign abort_hit = abort && (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    tiles_d = tiles_q;
    row_d   = row_q;
    tile_d  = tile_q;
    wait_d  = wait_q;
    sample  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rows_d  = cfg_out_rows;
          tiles_d = cfg_tiles;
          row_d   = '0;
          tile_d  = '0;
          // An empty frame still produces a done pulse, but never touches the line buffer.
          state_d = ((cfg_out_rows == '0) || (cfg_tiles == '0)) ? StDone : StFetch;
        end
      end
      StFetch: begin
        if (bus.rd_ack) begin
          if (CORE_LAT == 0) begin
            sample  = 1'b1;
            state_d = StEmit;
          end else begin
            wait_d  = 4'(CORE_LAT);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        // The counter reaches zero on this edge, so core_out is valid in this cycle.
        wait_d = wait_q - 4'd1;
        if (wait_q == 4'd1) begin
          sample  = 1'b1;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          if (tile_q == tiles_q - 1'b1) begin
            tile_d  = '0;
            row_d   = row_q + 1'b1;
            state_d = (row_q == rows_q - 1'b1) ? StDone : StFetch;
          end else begin
            tile_d  = tile_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort wins over any handshake completing in the same cycle.
    if (abort_hit) begin
      state_d = StIdle;
      sample  = 1'b0;
    end
  end

  // done trails the DONE state by one cycle so it coincides with busy dropping.
  assign done_d = (state_q == StDone) && !abort_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rows_q     <= '0;
      tiles_q    <= '0;
      row_q      <= '0;
      tile_q     <= '0;
      wait_q     <= '0;
      out_data_q <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      tiles_q <= tiles_d;
      row_q   <= row_d;
      tile_q  <= tile_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      if (sample) begin
        out_data_q <= bus.core_out;
        out_row_q  <= row_q;
        out_col_q  <= {tile_q, 2'b00};
      end
    end
  end

  assign bus.rd_req    = (state_q == StFetch);
  assign bus.rd_row    = row_q;
  assign bus.rd_col    = {tile_q, 2'b00};
  assign bus.out_valid = (state_q == StEmit);
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_col   = out_col_q;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;

`ifdef CONV_SCHED_PERF_EN
  logic [31:0] perf_q;
  logic        stall;

  assign stall = (bus.rd_req && !bus.rd_ack) || (bus.out_valid && !bus.out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      perf_q <= '0;
    end else if (stall && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule
